// File: rtl/instr_queue_if.sv
// Fetch/decode-side signal bundle for instr_queue; the queue takes the slave
// modport, the fetch/decode driver takes the master modport.
interface instr_queue_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0]          instr1;
    logic [WIDTH-1:0]          instr2;
    logic                      in_valid1;
    logic                      in_valid2;
    logic                      finish;
    logic                      flush;
    logic                      in_ready;
    logic [WIDTH-1:0]          dec_instr1;
    logic [WIDTH-1:0]          dec_instr2;
    logic                      dec_valid1;
    logic                      dec_valid2;
    logic [1:0]                dec_accept;
    logic [$clog2(DEPTH):0]    count;
    logic                      done;

    modport master (
        output instr1, instr2, in_valid1, in_valid2, finish, flush, dec_accept,
        input  in_ready, dec_instr1, dec_instr2, dec_valid1, dec_valid2, count, done
    );

    modport slave (
        input  instr1, instr2, in_valid1, in_valid2, finish, flush, dec_accept,
        output in_ready, dec_instr1, dec_instr2, dec_valid1, dec_valid2, count, done
    );
endinterface

// File: rtl/instr_queue.sv
// Dual-issue circular instruction queue between fetch and decode.
// Optional IQ_STATS_EN adds a saturating stall_cycles counter output.
module instr_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
`ifdef IQ_STATS_EN
    output logic [31:0]        stall_cycles,
`endif
    instr_queue_if.slave       bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             r_fin_q;

    logic             w_in_ready;
    logic             w_enq_fire;
    logic [1:0]       w_enq;
    logic [1:0]       w_acc;
    logic [1:0]       w_deq;
    logic [PW-1:0]    w_wr_ptr_p1;
    logic [PW-1:0]    w_rd_ptr_p1;

    // Credit comes from registered count only; same-cycle dequeue never helps.
    assign w_in_ready  = (r_count <= CW'(DEPTH - 2));
    assign w_enq_fire  = bus.in_valid1 && w_in_ready && !r_fin_q && !bus.flush;
    assign w_enq       = w_enq_fire ? (bus.in_valid2 ? 2'd2 : 2'd1) : 2'd0;
    assign w_acc       = (bus.dec_accept == 2'd3) ? 2'd2 : bus.dec_accept;
    assign w_deq       = (CW'(w_acc) > r_count) ? r_count[1:0] : w_acc;
    assign w_wr_ptr_p1 = r_wr_ptr + PW'(1);
    assign w_rd_ptr_p1 = r_rd_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_fin_q  <= 1'b0;
        end else begin
            if (bus.finish) begin
                r_fin_q <= 1'b1;
            end
            if (bus.flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                r_wr_ptr <= r_wr_ptr + PW'(w_enq);
                r_rd_ptr <= r_rd_ptr + PW'(w_deq);
                r_count  <= r_count + CW'(w_enq) - CW'(w_deq);
            end
        end
    end

    // Storage is deliberately unreset; output masking hides stale slots.
    always_ff @(posedge clk) begin
        if (w_enq_fire) begin
            r_mem[r_wr_ptr] <= bus.instr1;
            if (bus.in_valid2) begin
                r_mem[w_wr_ptr_p1] <= bus.instr2;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.count      = r_count;
    assign bus.dec_valid1 = (r_count >= CW'(1));
    assign bus.dec_valid2 = (r_count >= CW'(2));
    assign bus.dec_instr1 = bus.dec_valid1 ? r_mem[r_rd_ptr]    : '0;
    assign bus.dec_instr2 = bus.dec_valid2 ? r_mem[w_rd_ptr_p1] : '0;
    assign bus.done       = r_fin_q && (r_count == '0);

`ifdef IQ_STATS_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (bus.in_valid1 && !w_in_ready && !r_fin_q && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_instr_queue.sv
// Randomized self-checking bench for instr_queue against a queue-based model.
// Define IQ_STATS_EN to also check stall_cycles.
module tb_instr_queue;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 32;

    logic clk;
    logic rst;
`ifdef IQ_STATS_EN
    logic [31:0] stall_cycles;
`endif

    instr_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    instr_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef IQ_STATS_EN
        .stall_cycles (stall_cycles),
`endif
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] m_q [$];
    logic        m_fin;
    logic [31:0] m_stall;
    logic [31:0] seq_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int unsigned sz;
        sz = m_q.size();
        check("count",    32'(bus.count), sz);
        check("in_ready", 32'(bus.in_ready), 32'(sz <= DEPTH - 2));
        check("valid1",   32'(bus.dec_valid1), 32'(sz >= 1));
        check("valid2",   32'(bus.dec_valid2), 32'(sz >= 2));
        check("instr1",   bus.dec_instr1, (sz >= 1) ? m_q[0] : 32'd0);
        check("instr2",   bus.dec_instr2, (sz >= 2) ? m_q[1] : 32'd0);
        check("done",     32'(bus.done), 32'(m_fin && sz == 0));
`ifdef IQ_STATS_EN
        check("stall",    stall_cycles, m_stall);
`endif
    endtask

    // One cycle: apply inputs, check state-derived outputs, step the model.
    task automatic cycle(input logic r, input logic v1, input logic v2,
                         input logic [31:0] i1, input logic [31:0] i2,
                         input logic fin, input logic fl, input logic [1:0] acc);
        int unsigned sz, take, a;
        rst = r;
        bus.in_valid1 = v1; bus.in_valid2 = v2;
        bus.instr1 = i1;    bus.instr2 = i2;
        bus.finish = fin;   bus.flush = fl;  bus.dec_accept = acc;
        @(negedge clk);
        check_outputs();
        sz = m_q.size();
        if (r) begin
            m_q.delete();
            m_fin = 1'b0;
            m_stall = '0;
        end else begin
            if (v1 && sz > DEPTH - 2 && !m_fin && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (fl) begin
                m_q.delete();
            end else begin
                a = (acc == 2'd3) ? 2 : int'(acc);
                take = (a < sz) ? a : sz;
                repeat (take) void'(m_q.pop_front());
                if (v1 && sz <= DEPTH - 2 && !m_fin) begin
                    m_q.push_back(i1);
                    if (v2) m_q.push_back(i2);
                end
            end
            if (fin) m_fin = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic seq_pair(input logic [1:0] acc);
        cycle(1'b0, 1'b1, 1'b1, seq_val, seq_val + 1, 1'b0, 1'b0, acc);
        seq_val += 2;
    endtask

    initial begin
        bit drained;
        m_fin = 1'b0; m_stall = '0; seq_val = 32'd1;
        rst = 1'b1;
        bus.in_valid1 = 0; bus.in_valid2 = 0; bus.instr1 = 0; bus.instr2 = 0;
        bus.finish = 0; bus.flush = 0; bus.dec_accept = 0;
        @(posedge clk); #1;
        cycle(1'b1, 0, 0, 0, 0, 0, 0, 2'd0);

        // Fill until in_ready drops, then keep pushing against a full queue.
        repeat (6) seq_pair(2'd0);
        @(negedge clk);
        check("fill_count", 32'(bus.count), 32'd8);
        check("fill_head",  bus.dec_instr1, 32'd1);
        check("fill_next",  bus.dec_instr2, 32'd2);
        @(posedge clk); #1;
        repeat (5) cycle(1'b0, 1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 0, 0, 2'd0);

        // Drain to two, then sustained full-throughput traffic across wrap.
        repeat (3) cycle(1'b0, 0, 0, 0, 0, 0, 0, 2'd2);
        repeat (20) seq_pair(2'd2);

        // Odd traffic, including accept=3 with a single entry.
        repeat (6) cycle(1'b0, 0, 0, 0, 0, 0, 0, 2'd3);
        cycle(1'b0, 1'b1, 1'b0, 32'h55, 32'h66, 0, 0, 2'd0);
        cycle(1'b0, 0, 0, 0, 0, 0, 0, 2'd3);
        for (int k = 0; k < 10; k++)
            cycle(1'b0, 1'b1, 1'b0, $urandom, $urandom, 0, 0, 2'(k % 2));

        // Flush with simultaneous enqueue and dequeue at count=5.
        repeat (3) cycle(1'b0, 0, 0, 0, 0, 0, 0, 2'd3);
        seq_pair(2'd0); seq_pair(2'd0);
        cycle(1'b0, 1'b1, 1'b0, 32'h77, 0, 0, 0, 2'd0);
        cycle(1'b0, 1'b1, 1'b1, 32'h88, 32'h99, 0, 1'b1, 2'd2);
        seq_pair(2'd0);

        // Randomized traffic with occasional flushes.
        for (int k = 0; k < 400; k++)
            cycle(1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom,
                  1'b0, ($urandom_range(0, 19) == 0), 2'($urandom));

        // Finish with a final pair, then ignored inputs while draining.
        cycle(1'b0, 1'b1, 1'b1, 32'hAAAA0000, 32'hBBBB0000, 1'b1, 0, 2'd0);
        drained = 0;
        for (int k = 0; k < 40 && !drained; k++) begin
            cycle(1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom,
                  1'($urandom), 1'b0, 2'($urandom_range(0, 1)));
            if (m_q.size() == 0) drained = 1;
        end
        check("drain_bound", 32'(drained), 32'd1);
        repeat (3) cycle(1'b0, 1'b1, 1'b1, 32'h1234, 32'h5678, 0, 0, 2'd2);
        @(negedge clk);
        check("done_high", 32'(bus.done), 32'd1);
        @(posedge clk); #1;
        cycle(1'b1, 1'b1, 1'b1, 32'h1, 32'h2, 1'b1, 1'b1, 2'd2);

        // Post-reset: fill and hold to accumulate stalls, then flush.
        repeat (4) seq_pair(2'd0);
        repeat (5) cycle(1'b0, 1'b1, 1'b0, 32'hFEED, 0, 0, 0, 2'd0);
        cycle(1'b0, 0, 0, 0, 0, 0, 1'b1, 2'd0);
        for (int k = 0; k < 100; k++)
            cycle(1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom,
                  1'b0, ($urandom_range(0, 29) == 0), 2'($urandom));
        cycle(1'b0, 0, 0, 0, 0, 0, 0, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
